// File: rtl/if_id_skid_pkg.sv
// Shared definitions for the IF/ID skid buffer.
//   InstNop / InstHalt : instruction encodings the buffer must recognise or emit
//   halt_st_e          : halt FSM states (run, drain towards halt, halted)
//   entry_t            : one buffered slot {inst, pcadd2, valid}, 33 bits
package if_id_skid_pkg;

   localparam logic [15:0] InstNop  = 16'h0800;
   localparam logic [15:0] InstHalt = 16'h0000;

   typedef enum logic [1:0] {
      StRun    = 2'd0,
      StDrain  = 2'd1,
      StHalted = 2'd2
   } halt_st_e;

   typedef struct packed {
      logic [15:0] inst;
      logic [15:0] pcadd2;
      logic        valid;
   } entry_t;

endpackage

// File: rtl/if_id_entry.sv
// One 33-bit IF/ID buffer slot with load and clear.
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset, empties the slot
//   clear_i : empty the slot next cycle (wins over load_i)
//   load_i  : capture d_i next cycle
//   d_i     : entry to capture
//   q_o     : current slot contents
module if_id_entry
   import if_id_skid_pkg::*;
(
   input  logic   clk_i,
   input  logic   rst_ni,
   input  logic   clear_i,
   input  logic   load_i,
   input  entry_t d_i,
   output entry_t q_o
);

   entry_t q_d, q_q;

   always_comb begin
      q_d = q_q;
      if (clear_i) begin
         q_d = '0;
      end else if (load_i) begin
         q_d = d_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/if_id_skid.sv
// Two-entry IF/ID pipeline buffer with a registered ready and a halt tracker.
//   clk, rst (sync, active-low)
//   if_inst, if_pcadd2, if_valid : offer from fetch; if_ready : registered accept enable
//   stall_id, dmem_stall         : hold the head entry
//   flush                        : discard everything buffered
//   id_inst, id_pcadd2, id_valid : head entry towards decode (NOP / 0 when empty)
//   halt_n                       : drops once a HALT has been consumed by decode
module if_id_skid
   import if_id_skid_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] if_inst,
   input  logic [15:0] if_pcadd2,
   input  logic        if_valid,
   output logic        if_ready,
   input  logic        stall_id,
   input  logic        dmem_stall,
   input  logic        flush,
   output logic [15:0] id_inst,
   output logic [15:0] id_pcadd2,
   output logic        id_valid,
   output logic        halt_n
);

   entry_t   head_q, skid_q, head_d, in_entry;
   logic     head_load, head_clr, skid_load, skid_clr, skid_valid_nxt;
   logic     accept, consume, head_live;
   halt_st_e state_q, state_d;
   logic     if_ready_q, if_ready_d, halt_n_q, halt_n_d;

   always_comb begin
      in_entry        = '0;
      in_entry.inst   = if_inst;
      in_entry.pcadd2 = if_pcadd2;
      in_entry.valid  = 1'b1;
   end

   assign head_live = head_q.valid & (state_q != StHalted);
   assign accept    = if_valid & if_ready_q;
   assign consume   = head_live & ~stall_id & ~dmem_stall;

   // Skid is only ever occupied while head is, so "head empty" implies "skid empty".
   always_comb begin
      head_load = 1'b0;
      head_clr  = 1'b0;
      skid_load = 1'b0;
      skid_clr  = 1'b0;
      head_d    = in_entry;
      if (flush || (state_q == StHalted)) begin
         head_clr = 1'b1;
         skid_clr = 1'b1;
      end else if (!head_q.valid || consume) begin
         if (skid_q.valid) begin
            head_load = 1'b1;
            head_d    = skid_q;
            skid_clr  = 1'b1;
         end else if (accept) begin
            head_load = 1'b1;
         end else begin
            head_clr = 1'b1;
         end
      end else if (accept) begin
         skid_load = 1'b1;
      end
   end

   assign skid_valid_nxt = skid_clr ? 1'b0 : (skid_load ? 1'b1 : skid_q.valid);

   // A HALT offered alongside flush is not stored, so it must not start draining.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StRun: begin
            if (accept && !flush && (if_inst == InstHalt)) state_d = StDrain;
         end
         StDrain: begin
            if (consume && (head_q.inst == InstHalt)) state_d = StHalted;
            else if (flush)                           state_d = StRun;
         end
         StHalted: state_d = StHalted;
         default:  state_d = StRun;
      endcase
      if_ready_d = ~skid_valid_nxt & (state_d == StRun);
      halt_n_d   = (state_d != StHalted);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StRun;
         if_ready_q <= 1'b0;
         halt_n_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         if_ready_q <= if_ready_d;
         halt_n_q   <= halt_n_d;
      end
   end

   if_id_entry u_head (
      .clk_i   (clk),
      .rst_ni  (rst),
      .clear_i (head_clr),
      .load_i  (head_load),
      .d_i     (head_d),
      .q_o     (head_q)
   );

   if_id_entry u_skid (
      .clk_i   (clk),
      .rst_ni  (rst),
      .clear_i (skid_clr),
      .load_i  (skid_load),
      .d_i     (in_entry),
      .q_o     (skid_q)
   );

   assign if_ready  = if_ready_q;
   assign halt_n    = halt_n_q;
   assign id_valid  = head_live;
   assign id_inst   = head_live ? head_q.inst : InstNop;
   assign id_pcadd2 = head_live ? head_q.pcadd2 : 16'h0000;

endmodule

// File: tb/tb_if_id_skid.sv
// Directed bench for if_id_skid. Observation vector packs
// {id_valid, id_inst, id_pcadd2, if_ready, halt_n} = 35 bits.
module tb_if_id_skid;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] if_inst, if_pcadd2;
   logic        if_valid, if_ready, stall_id, dmem_stall, flush;
   logic [15:0] id_inst, id_pcadd2;
   logic        id_valid, halt_n;
   logic [34:0] obs, exp_v;
   int          vecs = 0;
   int          errs = 0;

   always #5 clk = ~clk;

   if_id_skid dut (
      .clk        (clk),
      .rst        (rst),
      .if_inst    (if_inst),
      .if_pcadd2  (if_pcadd2),
      .if_valid   (if_valid),
      .if_ready   (if_ready),
      .stall_id   (stall_id),
      .dmem_stall (dmem_stall),
      .flush      (flush),
      .id_inst    (id_inst),
      .id_pcadd2  (id_pcadd2),
      .id_valid   (id_valid),
      .halt_n     (halt_n)
   );

   assign obs = {id_valid, id_inst, id_pcadd2, if_ready, halt_n};

   task automatic drive(input logic v, input logic [15:0] inst, input logic [15:0] pc,
                        input logic st, input logic dm, input logic fl);
      if_valid   = v;
      if_inst    = inst;
      if_pcadd2  = pc;
      stall_id   = st;
      dmem_stall = dm;
      flush      = fl;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drive(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
      step();
      step();
      exp_v = {1'b0, 16'h0800, 16'h0000, 1'b0, 1'b1};
      vecs++;
      if (obs !== exp_v) begin
         errs++;
         $display("FAIL reset_hold: got %h expected %h", obs, exp_v);
      end
      rst = 1'b1;
      drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
      step();
      exp_v = {1'b0, 16'h0800, 16'h0000, 1'b1, 1'b1};
      vecs++;
      if (obs !== exp_v) begin
         errs++;
         $display("FAIL reset_release: got %h expected %h", obs, exp_v);
      end
   endtask

   task automatic test_stream();
      logic [15:0] insts [3];
      insts = '{16'h1000, 16'h1001, 16'h1002};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, insts[i], 16'(2 * (i + 1)), 1'b0, 1'b0, 1'b0);
         step();
         exp_v = {1'b1, insts[i], 16'(2 * (i + 1)), 1'b1, 1'b1};
         vecs++;
         if (obs !== exp_v) begin
            errs++;
            $display("FAIL stream_%0d: got %h expected %h", i, obs, exp_v);
         end
      end
      // HALT encoding with if_valid=0 must be ignored.
      drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
      step();
      step();
      exp_v = {1'b0, 16'h0800, 16'h0000, 1'b1, 1'b1};
      vecs++;
      if (obs !== exp_v) begin
         errs++;
         $display("FAIL stream_drain_invalid_halt: got %h expected %h", obs, exp_v);
      end
   endtask

   task automatic test_skid();
      logic [34:0] exps [6];
      exps = '{{1'b1, 16'hA000, 16'h0010, 1'b1, 1'b1},
               {1'b1, 16'hA000, 16'h0010, 1'b0, 1'b1},
               {1'b1, 16'hA000, 16'h0010, 1'b0, 1'b1},
               {1'b1, 16'hA000, 16'h0010, 1'b0, 1'b1},
               {1'b1, 16'hA001, 16'h0012, 1'b1, 1'b1},
               {1'b0, 16'h0800, 16'h0000, 1'b1, 1'b1}};
      for (int i = 0; i < 6; i++) begin
         case (i)
            0: drive(1'b1, 16'hA000, 16'h0010, 1'b0, 1'b0, 1'b0);
            1: drive(1'b1, 16'hA001, 16'h0012, 1'b1, 1'b0, 1'b0);
            2: drive(1'b1, 16'hA002, 16'h0014, 1'b1, 1'b0, 1'b0);
            3: drive(1'b1, 16'hA002, 16'h0014, 1'b1, 1'b0, 1'b0);
            default: drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
         endcase
         step();
         vecs++;
         if (obs !== exps[i]) begin
            errs++;
            $display("FAIL skid_%0d: got %h expected %h", i, obs, exps[i]);
         end
      end
   endtask

   task automatic test_flush();
      logic [34:0] exps [6];
      exps = '{{1'b1, 16'hC000, 16'h0020, 1'b1, 1'b1},
               {1'b1, 16'hC000, 16'h0020, 1'b0, 1'b1},
               {1'b0, 16'h0800, 16'h0000, 1'b1, 1'b1},
               {1'b0, 16'h0800, 16'h0000, 1'b1, 1'b1},
               {1'b1, 16'hB001, 16'h0024, 1'b1, 1'b1},
               {1'b0, 16'h0800, 16'h0000, 1'b1, 1'b1}};
      for (int i = 0; i < 6; i++) begin
         case (i)
            0: drive(1'b1, 16'hC000, 16'h0020, 1'b0, 1'b0, 1'b0);
            1: drive(1'b1, 16'hC001, 16'h0022, 1'b0, 1'b1, 1'b0);
            2: drive(1'b1, 16'hB000, 16'h0030, 1'b0, 1'b0, 1'b1);
            3: drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
            4: drive(1'b1, 16'hB001, 16'h0024, 1'b0, 1'b0, 1'b0);
            default: drive(1'b1, 16'hB002, 16'h0026, 1'b0, 1'b0, 1'b1);
         endcase
         step();
         vecs++;
         if (obs !== exps[i]) begin
            errs++;
            $display("FAIL flush_%0d: got %h expected %h", i, obs, exps[i]);
         end
      end
      drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
      step();
      vecs++;
      if (id_valid !== 1'b0) begin
         errs++;
         $display("FAIL flush_no_store: got id_valid %b expected 0", id_valid);
      end
   endtask

   task automatic test_halt_flush();
      logic [34:0] exps [5];
      exps = '{{1'b1, 16'h0000, 16'h0030, 1'b0, 1'b1},
               {1'b1, 16'h0000, 16'h0030, 1'b0, 1'b1},
               {1'b0, 16'h0800, 16'h0000, 1'b1, 1'b1},
               {1'b1, 16'hD000, 16'h0040, 1'b1, 1'b1},
               {1'b0, 16'h0800, 16'h0000, 1'b1, 1'b1}};
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: drive(1'b1, 16'h0000, 16'h0030, 1'b0, 1'b0, 1'b0);
            1: drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
            2: drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
            3: drive(1'b1, 16'hD000, 16'h0040, 1'b0, 1'b0, 1'b0);
            default: drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
         endcase
         step();
         vecs++;
         if (obs !== exps[i]) begin
            errs++;
            $display("FAIL halt_flush_%0d: got %h expected %h", i, obs, exps[i]);
         end
      end
   endtask

   task automatic test_halt();
      logic [34:0] exps [4];
      exps = '{{1'b1, 16'h0000, 16'h0050, 1'b0, 1'b1},
               {1'b0, 16'h0800, 16'h0000, 1'b0, 1'b0},
               {1'b0, 16'h0800, 16'h0000, 1'b0, 1'b0},
               {1'b0, 16'h0800, 16'h0000, 1'b0, 1'b0}};
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: drive(1'b1, 16'h0000, 16'h0050, 1'b0, 1'b0, 1'b0);
            1: drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
            2: drive(1'b1, 16'hE000, 16'h0052, 1'b0, 1'b0, 1'b1);
            default: drive(1'b1, 16'hE001, 16'h0054, 1'b0, 1'b0, 1'b0);
         endcase
         step();
         vecs++;
         if (obs !== exps[i]) begin
            errs++;
            $display("FAIL halt_%0d: got %h expected %h", i, obs, exps[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [34:0] exps [8];
      exps = '{{1'b0, 16'h0800, 16'h0000, 1'b0, 1'b1},
               {1'b0, 16'h0800, 16'h0000, 1'b1, 1'b1},
               {1'b1, 16'hF000, 16'h0060, 1'b1, 1'b1},
               {1'b1, 16'hF000, 16'h0060, 1'b0, 1'b1},
               {1'b0, 16'h0800, 16'h0000, 1'b0, 1'b1},
               {1'b0, 16'h0800, 16'h0000, 1'b1, 1'b1},
               {1'b1, 16'h1234, 16'h0070, 1'b1, 1'b1},
               {1'b0, 16'h0800, 16'h0000, 1'b1, 1'b1}};
      for (int i = 0; i < 8; i++) begin
         rst = !((i == 0) || (i == 4));
         case (i)
            0, 1: drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
            2: drive(1'b1, 16'hF000, 16'h0060, 1'b0, 1'b0, 1'b0);
            3, 4: drive(1'b1, 16'h0000, 16'h0062, 1'b1, 1'b0, 1'b0);
            5: drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
            6: drive(1'b1, 16'h1234, 16'h0070, 1'b0, 1'b0, 1'b0);
            default: drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
         endcase
         step();
         vecs++;
         if (obs !== exps[i]) begin
            errs++;
            $display("FAIL reset_mid_%0d: got %h expected %h", i, obs, exps[i]);
         end
      end
      rst = 1'b1;
   endtask

   task automatic test_flush_halt_consume();
      drive(1'b1, 16'h0000, 16'h0080, 1'b0, 1'b0, 1'b0);
      step();
      exp_v = {1'b1, 16'h0000, 16'h0080, 1'b0, 1'b1};
      vecs++;
      if (obs !== exp_v) begin
         errs++;
         $display("FAIL fhc_accept: got %h expected %h", obs, exp_v);
      end
      drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
      step();
      exp_v = {1'b0, 16'h0800, 16'h0000, 1'b0, 1'b0};
      vecs++;
      if (obs !== exp_v) begin
         errs++;
         $display("FAIL fhc_halted: got %h expected %h", obs, exp_v);
      end
      drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b0;
      drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_stream();
      test_skid();
      test_flush();
      test_halt_flush();
      test_halt();
      test_reset_mid();
      test_flush_halt_consume();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/if_id_skid.md
IF_ID_SKID -- requirements
Module: if_id_skid

Interface
REQ-001 clk  in  1  single rising-edge clock for all state.
REQ-002 rst  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-003 if_inst  in  16  instruction from fetch (0x0800 = NOP, 0x0000 = HALT).
REQ-004 if_pcadd2  in  16  PC+2 of if_inst.
REQ-005 if_valid  in  1  fetch offers a real instruction this cycle; inserted NOPs arrive with if_valid=0.
REQ-006 if_ready  out  1  block accepts an offer this cycle; fetch holds its PC when 0.
REQ-007 stall_id  in  1  decode hazard stall; head entry is not consumed.
REQ-008 dmem_stall  in  1  data-memory stall; head entry is not consumed.
REQ-009 flush  in  1  taken branch resolved downstream; discard all buffered instructions.
REQ-010 id_inst  out  16  head instruction to decode; 0x0800 when id_valid=0.
REQ-011 id_pcadd2  out  16  head PC+2; 0x0000 when id_valid=0.
REQ-012 id_valid  out  1  head entry holds a real instruction.
REQ-013 halt_n  out  1  0 once HALT has been consumed by decode; feeds the PC write enable.

Function
REQ-014 Storage: two entries, head (drives id_*) and skid, each {inst[15:0], pcadd2[15:0], valid}; occupancy 0/1/2.
REQ-015 Accept = if_valid & if_ready; consume = id_valid & ~stall_id & ~dmem_stall.
REQ-016 if_ready SHALL be a registered signal: 1 iff skid entry empty and halt FSM in RUN; no combinational path from stall_id/dmem_stall/flush to if_ready.
REQ-017 Occupancy 0: accept loads head next cycle (1-cycle latency, if_* to id_*).
REQ-018 Occupancy 1: accept without consume loads skid; accept with consume loads head, skid stays empty; consume without accept empties head.
REQ-019 Occupancy 2: consume moves skid into head, skid empties; no accept possible (if_ready=0).
REQ-020 Order SHALL be strictly FIFO; no entry dropped or duplicated under any stall/accept combination.
REQ-021 flush SHALL empty both entries next cycle, overriding a simultaneous accept and consume; id_valid=0 the cycle after flush.
REQ-022 Halt FSM states RUN, DRAIN, HALTED; reset state RUN.
REQ-023 RUN->DRAIN when an accepted instruction equals 0x0000; in DRAIN if_ready=0.
REQ-024 DRAIN->HALTED when the HALT entry is consumed; halt_n=0 from the following cycle, held until reset; id_valid=0 in HALTED.
REQ-025 DRAIN->RUN on flush (HALT was on the wrong path); HALTED ignores flush.
REQ-026 Simultaneous flush and HALT consume: consume wins, FSM->HALTED.
REQ-027 Inputs with if_valid=0 are never stored, regardless of if_inst value.

Reset
REQ-028 While rst=0 at a clock edge: both entries invalid, FSM RUN, if_ready=0 for that cycle and 1 the cycle after rst returns to 1.
REQ-029 Reset values: id_inst=0x0800, id_pcadd2=0x0000, id_valid=0, halt_n=1.
REQ-030 Reset mid-operation (any occupancy, any FSM state) SHALL discard all contents with no partial update.

Structure
REQ-031 Shared package holds NOP (0x0800) and HALT (0x0000) encodings and halt FSM state encodings.
REQ-032 One sub-module: if_id_entry, a 33-bit register with load/clear, instantiated twice (head, skid).

Verification
REQ-033 Stream 0x1000,0x1001,0x1002 at PC+2 0x0002,0x0004,0x0006, no stalls -> same values on id_* one cycle later, id_valid=1 each cycle.
REQ-034 Offer 0xA000 then 0xA001 with stall_id=1 raised in cycle 1 for 3 cycles -> occupancy 2, if_ready=0; on release 0xA000 then 0xA001 emitted in order.
REQ-035 Occupancy 2 with flush=1 and if_valid=1 (0xB000) -> next cycle id_valid=0, id_inst=0x0800, 0xB000 not stored.
REQ-036 Accept 0x0000, then consume -> if_ready=0 from next cycle, halt_n=0 one cycle after consume, stays 0 with flush and new offers.
REQ-037 Accept 0x0000, dmem_stall=1, then flush -> FSM RUN, halt_n=1, if_ready=1 next cycle.
REQ-038 rst=0 asserted with occupancy 2 in DRAIN -> next cycle id_valid=0, id_inst=0x0800, halt_n=1, FSM RUN.
